// File: rtl/data_mem_dump.sv
// data_mem_dump: MEM-stage byte-lane data RAM with a valid/ready dump engine streaming every word to the debug unit
// Ports: i_clk/i_reset_n (async active-low); pipeline access i_enable, i_read, i_write, i_word_size,
//   i_addr, i_write_data -> o_read_data (lane-aligned to bit 0), o_misaligned;
//   dump i_dump_start, i_dump_ready -> o_dump_valid, o_dump_addr, o_dump_data, o_dump_last, o_dump_done, o_busy.
// Optional: DMEM_ALIGN_CHECK_EN flags misaligned HALF/WORD accesses and suppresses them.
module data_mem_dump #(
  parameter int DATA_SIZE = 32,
  parameter int ADDR_SIZE = 7,
  parameter int TYPE_SIZE = 3,
  parameter logic [TYPE_SIZE-1:0] BYTE_WORD = 0,
  parameter logic [TYPE_SIZE-1:0] HALF_WORD = 1,
  parameter logic [TYPE_SIZE-1:0] COMPLETE_WORD = 2
) (
  input  logic                 i_clk,
  input  logic                 i_reset_n,
  input  logic                 i_enable,
  input  logic                 i_read,
  input  logic                 i_write,
  input  logic [TYPE_SIZE-1:0] i_word_size,
  input  logic [ADDR_SIZE-1:0] i_addr,
  input  logic [DATA_SIZE-1:0] i_write_data,
  output logic [DATA_SIZE-1:0] o_read_data,
  output logic                 o_misaligned,
  input  logic                 i_dump_start,
  input  logic                 i_dump_ready,
  output logic                 o_dump_valid,
  output logic [ADDR_SIZE-1:0] o_dump_addr,
  output logic [DATA_SIZE-1:0] o_dump_data,
  output logic                 o_dump_last,
  output logic                 o_dump_done,
  output logic                 o_busy
);
  localparam int DEPTH = 2 ** (ADDR_SIZE - 2);
  localparam int CW = ADDR_SIZE - 2;
  localparam int LANES = DATA_SIZE / 8;
  typedef enum logic [1:0] {IDLE, DUMP, DONE} state_t;
  logic [DATA_SIZE-1:0] mem [DEPTH];
  logic [CW-1:0] widx, cnt;
  logic [DATA_SIZE-1:0] w, wd;
  logic [LANES-1:0] be;
  logic is_byte, is_half, is_word, mis, we;
  state_t state, nxt;
  assign widx = i_addr[ADDR_SIZE-1:2];
  assign w = mem[widx];
  assign is_byte = i_word_size == BYTE_WORD;
  assign is_half = i_word_size == HALF_WORD;
  assign is_word = i_word_size == COMPLETE_WORD;
`ifdef DMEM_ALIGN_CHECK_EN
  assign mis = (i_read | i_write) & ((is_half & i_addr[0]) | (is_word & |i_addr[1:0]));
`else
  assign mis = 1'b0;
`endif
  assign o_misaligned = mis;
  // Store data is replicated across lanes so the byte enables alone pick the target lanes
  assign wd = is_byte ? {LANES{i_write_data[7:0]}} : is_half ? {(LANES/2){i_write_data[15:0]}} : i_write_data;
  assign be = is_byte ? LANES'(1) << i_addr[1:0] : is_half ? LANES'(3) << {i_addr[1], 1'b0} : {LANES{is_word}};
  assign we = i_write & i_enable & ~o_busy & ~mis;
  always_comb begin
    o_read_data = '0;
    if (i_read && !mis)
      o_read_data = is_byte ? w >> {i_addr[1:0], 3'b000} : is_half ? w >> {i_addr[1], 4'b0000} : is_word ? w : '0;
  end
  always_ff @(posedge i_clk)
    for (int l = 0; l < LANES; l++)
      if (we && be[l]) mem[widx][8*l +: 8] <= wd[8*l +: 8];
  always_ff @(posedge i_clk or negedge i_reset_n)
    if (!i_reset_n) begin
      state <= IDLE;
      cnt <= '0;
    end else begin
      state <= nxt;
      cnt <= state == IDLE ? '0 : (state == DUMP && i_dump_ready && !(&cnt)) ? cnt + 1'b1 : cnt;
    end
  always_comb
    nxt = state == IDLE ? (i_dump_start ? DUMP : IDLE) :
          state == DUMP ? ((i_dump_ready && &cnt) ? DONE : DUMP) : IDLE;
  always_comb begin
    o_dump_valid = state == DUMP;
    o_dump_last = o_dump_valid & (&cnt);
    o_dump_addr = o_dump_valid ? {cnt, 2'b00} : '0;
    o_dump_data = o_dump_valid ? mem[cnt] : '0;
    o_dump_done = state == DONE;
    o_busy = state != IDLE;
  end
endmodule

// File: tb/tb_data_mem_dump.sv
// tb_data_mem_dump: table, sequence and randomized checks of data_mem_dump against a byte-array reference model
module tb_data_mem_dump;
  localparam logic [2:0] B = 3'd0, H = 3'd1, W = 3'd2;
  logic clk, rst_n, en, rd, wr, start, ready;
  logic [2:0] sz;
  logic [6:0] addr;
  logic [31:0] wdata, rdata, ddata;
  logic mis, dvalid, dlast, ddone, busy;
  logic [6:0] daddr;
  int errors = 0, checks = 0, beat, dones;
  logic [7:0] mb [128];
  typedef struct {logic wr, rd, en; logic [2:0] sz; logic [6:0] a; logic [31:0] wd, exp; logic mis;} vec_t;
  vec_t tv[$];
  data_mem_dump dut (
    .i_clk(clk), .i_reset_n(rst_n), .i_enable(en), .i_read(rd), .i_write(wr),
    .i_word_size(sz), .i_addr(addr), .i_write_data(wdata), .o_read_data(rdata),
    .o_misaligned(mis), .i_dump_start(start), .i_dump_ready(ready), .o_dump_valid(dvalid),
    .o_dump_addr(daddr), .o_dump_data(ddata), .o_dump_last(dlast), .o_dump_done(ddone), .o_busy(busy));
  initial clk = 0;
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  function automatic logic mmis(logic r, logic w_, logic [2:0] s, logic [6:0] a);
`ifdef DMEM_ALIGN_CHECK_EN
    return (r | w_) && ((s == H && a[0]) || (s == W && a[1:0] != 2'b00));
`else
    return 1'b0;
`endif
  endfunction
  function automatic logic [31:0] mword(int idx);
    return {mb[idx*4+3], mb[idx*4+2], mb[idx*4+1], mb[idx*4]};
  endfunction
  function automatic logic [31:0] mread(logic r, logic [2:0] s, logic [6:0] a);
    logic [31:0] v;
    int off;
    v = mword(int'(a) / 4);
    off = int'(a) % 4;
    if (!r || s > W || mmis(r, 1'b0, s, a)) return 32'h0;
    if (s == B) return v >> (8 * off);
    if (s == H) return v >> (8 * (off & 2));
    return v;
  endfunction
  task automatic mwrite(input logic [2:0] s, input logic [6:0] a, input logic [31:0] d);
    int base;
    base = s == B ? int'(a) : s == H ? int'(a) & ~1 : int'(a) & ~3;
    for (int i = 0; i < (s == B ? 1 : s == H ? 2 : 4); i++) mb[base+i] = d[8*i +: 8];
  endtask
  task automatic step(input logic w_, r, e, input logic [2:0] s, input logic [6:0] a, input logic [31:0] d,
                      input logic tab, input logic [31:0] exp, input logic exp_m);
    @(negedge clk);
    wr = w_; rd = r; en = e; sz = s; addr = a; wdata = d;
    #1;
    chk("rdata", rdata, tab ? exp : mread(r, s, a));
    chk("misaligned", {31'b0, mis}, {31'b0, tab ? exp_m : mmis(r, w_, s, a)});
    @(posedge clk);
    if (w_ && e && s <= W && !mmis(r, w_, s, a)) mwrite(s, a, d);
  endtask
  task automatic beat_cycle(input logic rdy, input logic st, input logic inject);
    @(negedge clk);
    ready = rdy; start = st;
    wr = inject; en = inject; rd = 0; sz = W; addr = 7'h10; wdata = 32'hFFFFFFFF;
    #1;
    if (ddone) dones++;
    if (dvalid) begin
      chk("dump_addr", {25'b0, daddr}, beat * 4);
      chk("dump_data", ddata, mword(beat));
      chk("dump_last", {31'b0, dlast}, {31'b0, beat == 31});
      if (rdy) beat++;
    end
    @(posedge clk);
  endtask
  initial begin
    rst_n = 0; en = 0; rd = 0; wr = 0; sz = W; addr = 0; wdata = 0; start = 0; ready = 0;
    @(posedge clk);
    @(negedge clk);
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_valid", {31'b0, dvalid}, 0);
    chk("rst_done", {31'b0, ddone}, 0);
    rst_n = 1;
    for (int i = 0; i < 32; i++) step(1, 0, 1, W, 7'(i * 4), i * 3, 1, 0, 0);
    // full dump with ready toggling every other cycle
    beat = 0; dones = 0;
    beat_cycle(0, 1, 0);
    for (int c = 0; c < 200 && !(beat == 32 && !busy); c++) beat_cycle(c % 2 == 1, 0, 0);
    for (int c = 0; c < 3; c++) beat_cycle(1, 0, 0);
    chk("dump_beats", beat, 32);
    chk("dump_done_once", dones, 1);
    chk("busy_after", {31'b0, busy}, 0);
    // writes while busy are dropped, start while busy ignored
    beat = 0; dones = 0;
    beat_cycle(1, 1, 0);
    beat_cycle(1, 0, 0);
    beat_cycle(1, 0, 0);
    beat_cycle(0, 1, 1);
    for (int c = 0; c < 100 && !(beat == 32 && !busy); c++) beat_cycle(1, 0, 0);
    chk("busy_beats", beat, 32);
    chk("busy_done", dones, 1);
    step(0, 1, 1, W, 7'h10, 0, 1, 32'd12, 0);
    // reset mid-dump at cnt=5, then restart from address 0
    beat = 0; dones = 0;
    beat_cycle(1, 1, 0);
    for (int c = 0; c < 5; c++) beat_cycle(1, 0, 0);
    chk("pre_rst_beats", beat, 5);
    @(negedge clk);
    rst_n = 0;
    #1;
    chk("mid_rst_valid", {31'b0, dvalid}, 0);
    chk("mid_rst_busy", {31'b0, busy}, 0);
    chk("mid_rst_last", {31'b0, dlast}, 0);
    @(negedge clk);
    rst_n = 1;
    beat = 0; dones = 0;
    beat_cycle(1, 1, 0);
    for (int c = 0; c < 100 && !(beat == 32 && !busy); c++) beat_cycle(1, 0, 0);
    chk("restart_beats", beat, 32);
    chk("restart_done", dones, 1);
    start = 0; ready = 0;
    // directed access vectors
    tv.push_back('{1'b1, 1'b0, 1'b1, W, 7'h08, 32'hDEADBEEF, 32'h0, 1'b0});
    tv.push_back('{1'b0, 1'b1, 1'b1, B, 7'h0B, 32'h0, 32'h000000DE, 1'b0});
    tv.push_back('{1'b0, 1'b1, 1'b1, H, 7'h0A, 32'h0, 32'h0000DEAD, 1'b0});
    tv.push_back('{1'b0, 1'b1, 1'b1, B, 7'h08, 32'h0, 32'hDEADBEEF, 1'b0});
    tv.push_back('{1'b1, 1'b0, 1'b1, W, 7'h04, 32'h11223344, 32'h0, 1'b0});
    tv.push_back('{1'b1, 1'b0, 1'b1, B, 7'h05, 32'hFFFFFFAA, 32'h0, 1'b0});
    tv.push_back('{1'b0, 1'b1, 1'b1, W, 7'h04, 32'h0, 32'h1122AA44, 1'b0});
    tv.push_back('{1'b1, 1'b0, 1'b0, W, 7'h04, 32'h0, 32'h0, 1'b0});
    tv.push_back('{1'b0, 1'b1, 1'b1, W, 7'h04, 32'h0, 32'h1122AA44, 1'b0});
    tv.push_back('{1'b0, 1'b1, 1'b1, 3'd3, 7'h04, 32'h0, 32'h0, 1'b0});
    tv.push_back('{1'b1, 1'b0, 1'b1, 3'd6, 7'h04, 32'h0, 32'h0, 1'b0});
    tv.push_back('{1'b0, 1'b1, 1'b1, W, 7'h04, 32'h0, 32'h1122AA44, 1'b0});
    tv.push_back('{1'b1, 1'b1, 1'b1, W, 7'h04, 32'h55667788, 32'h1122AA44, 1'b0});
    tv.push_back('{1'b0, 1'b1, 1'b1, W, 7'h04, 32'h0, 32'h55667788, 1'b0});
    tv.push_back('{1'b1, 1'b0, 1'b1, W, 7'h00, 32'hCAFEF00D, 32'h0, 1'b0});
`ifdef DMEM_ALIGN_CHECK_EN
    tv.push_back('{1'b1, 1'b0, 1'b1, H, 7'h01, 32'h00001234, 32'h0, 1'b1});
    tv.push_back('{1'b0, 1'b1, 1'b1, W, 7'h00, 32'h0, 32'hCAFEF00D, 1'b0});
`else
    tv.push_back('{1'b1, 1'b0, 1'b1, H, 7'h01, 32'h00001234, 32'h0, 1'b0});
    tv.push_back('{1'b0, 1'b1, 1'b1, W, 7'h00, 32'h0, 32'hCAFE1234, 1'b0});
`endif
    tv.push_back('{1'b0, 1'b1, 1'b1, H, 7'h02, 32'h0, 32'h0000CAFE, 1'b0});
    tv.push_back('{1'b0, 1'b1, 1'b1, B, 7'h06, 32'h0, 32'h00005566, 1'b0});
    tv.push_back('{1'b0, 1'b0, 1'b1, W, 7'h08, 32'h0, 32'h0, 1'b0});
    foreach (tv[i]) step(tv[i].wr, tv[i].rd, tv[i].en, tv[i].sz, tv[i].a, tv[i].wd, 1, tv[i].exp, tv[i].mis);
    // randomized accesses against the byte-array model
    for (int i = 0; i < 400; i++)
      step(1'($urandom % 2), 1'($urandom % 2), 1'($urandom % 4 != 0),
           ($urandom % 4 == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2)),
           7'($urandom), $urandom, 0, 0, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
